// File: rtl/alu_rr_pkg.sv
// Shared types and encodings for the R-type ALU sequencer and its legality check.
// No logic, no latency, no flow control.
package alu_rr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ_RS1,
    ST_READ_RS2,
    ST_CAPTURE_B,
    ST_EXECUTE,
    ST_WAIT,
    ST_WRITEBACK,
    ST_ERROR
  } state_t;

  localparam logic [6:0] FUNCT7_BASE    = 7'h00;
  localparam logic [6:0] FUNCT7_ALT     = 7'h20;
  localparam logic [2:0] FUNCT3_ADD_SUB = 3'd0;
  localparam logic [2:0] FUNCT3_SRL_SRA = 3'd5;

endpackage

// File: rtl/alu_rr_legal_check.sv
// funct3/funct7 legality for R-type ops; purely combinational, zero latency, no flow control.
// Shared with the decoder so both agree on what is encodable.
module alu_rr_legal_check
  import alu_rr_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic       legal
);

  // The alternate funct7 only modifies ADD (into SUB) and SRL (into SRA).
  assign legal = (funct7 == FUNCT7_BASE) ||
                 ((funct7 == FUNCT7_ALT) &&
                  ((funct3 == FUNCT3_ADD_SUB) || (funct3 == FUNCT3_SRL_SRA)));

endmodule

// File: rtl/alu_rr_sequencer.sv
// Runs one R-type op: read rs1, read rs2, strobe the ALU, wait ALU_LATENCY, write rd.
// Latency 4+ALU_LATENCY cycles to retire; issue_ready is low for the whole sequence.
module alu_rr_sequencer
  import alu_rr_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int ALU_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  issue_valid,
  output logic                  issue_ready,
  input  logic [REG_ADDR_W-1:0] issue_rs1,
  input  logic [REG_ADDR_W-1:0] issue_rs2,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic [2:0]            issue_funct3,
  input  logic [6:0]            issue_funct7,
  output logic [REG_ADDR_W-1:0] rf_read_addr,
  input  logic [XLEN-1:0]       rf_read_data,
  output logic                  alu_enable,
  output logic [2:0]            alu_funct3,
  output logic [6:0]            alu_funct7,
  output logic [XLEN-1:0]       alu_rs1_value,
  output logic [XLEN-1:0]       alu_rs2_value,
  input  logic [XLEN-1:0]       alu_rd_value,
  output logic                  rf_write_enable,
  output logic [REG_ADDR_W-1:0] rf_write_addr,
  output logic [XLEN-1:0]       rf_write_data,
  output logic                  done,
  output logic                  illegal
);

  localparam logic [2:0] LAT_INIT = 3'(ALU_LATENCY);

  state_t                state;
  logic [REG_ADDR_W-1:0] rs2_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [2:0]            lat_cnt;
  logic                  wb_phase;
  logic                  issue_legal;
  logic                  accept;

  alu_rr_legal_check u_legal (
    .funct3 (issue_funct3),
    .funct7 (issue_funct7),
    .legal  (issue_legal)
  );

  assign accept = issue_valid && issue_ready;

  // The ALU result only becomes valid in the writeback cycle itself, so it is
  // passed through under a registered qualifier rather than re-registered.
  assign rf_write_data = wb_phase ? alu_rd_value : '0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= ST_IDLE;
      issue_ready     <= 1'b1;
      rs2_q           <= '0;
      rd_q            <= '0;
      lat_cnt         <= '0;
      wb_phase        <= 1'b0;
      rf_read_addr    <= '0;
      alu_enable      <= 1'b0;
      alu_funct3      <= '0;
      alu_funct7      <= '0;
      alu_rs1_value   <= '0;
      alu_rs2_value   <= '0;
      rf_write_enable <= 1'b0;
      rf_write_addr   <= '0;
      done            <= 1'b0;
      illegal         <= 1'b0;
    end else begin
      rf_read_addr    <= '0;
      alu_enable      <= 1'b0;
      rf_write_enable <= 1'b0;
      rf_write_addr   <= '0;
      wb_phase        <= 1'b0;
      done            <= 1'b0;
      illegal         <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            issue_ready <= 1'b0;
            rs2_q       <= issue_rs2;
            rd_q        <= issue_rd;
            alu_funct3  <= issue_funct3;
            alu_funct7  <= issue_funct7;
            if (issue_legal) begin
              state        <= ST_READ_RS1;
              rf_read_addr <= issue_rs1;
            end else begin
              state   <= ST_ERROR;
              done    <= 1'b1;
              illegal <= 1'b1;
            end
          end
        end
        ST_READ_RS1: begin
          state        <= ST_READ_RS2;
          rf_read_addr <= rs2_q;
        end
        ST_READ_RS2: begin
          state         <= ST_CAPTURE_B;
          alu_rs1_value <= rf_read_data;
        end
        ST_CAPTURE_B: begin
          state         <= ST_EXECUTE;
          alu_rs2_value <= rf_read_data;
          alu_enable    <= 1'b1;
          lat_cnt       <= LAT_INIT;
        end
        // EXECUTE counts as the first latency cycle, so latency 1 skips WAIT.
        ST_EXECUTE, ST_WAIT: begin
          lat_cnt <= lat_cnt - 3'd1;
          if (lat_cnt == 3'd1) begin
            state           <= ST_WRITEBACK;
            rf_write_enable <= (rd_q != '0);
            rf_write_addr   <= rd_q;
            wb_phase        <= 1'b1;
            done            <= 1'b1;
          end else begin
            state <= ST_WAIT;
          end
        end
        ST_WRITEBACK, ST_ERROR: begin
          state       <= ST_IDLE;
          issue_ready <= 1'b1;
        end
        default: begin
          state       <= ST_IDLE;
          issue_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_rr_sequencer.sv
// Scoreboarded bench: instance 0 runs ALU_LATENCY=1, instance 1 runs ALU_LATENCY=3.
// A behavioural register file and ALU sit around each sequencer.
module tb_alu_rr_sequencer;

  typedef struct {
    int          inst;
    int          acc;
    int          lat;
    logic        legal;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a, b, res;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        issue_valid [2];
  logic [4:0]  issue_rs1, issue_rs2, issue_rd;
  logic [2:0]  issue_funct3;
  logic [6:0]  issue_funct7;
  logic        issue_ready [2];
  logic [4:0]  raddr [2];
  logic        alu_en [2];
  logic [2:0]  a_f3 [2];
  logic [6:0]  a_f7 [2];
  logic [31:0] op_a [2], op_b [2];
  logic        we [2];
  logic [4:0]  waddr [2];
  logic [31:0] wdata [2];
  logic        done [2], ill [2];

  logic [31:0] rf_mem [32];
  exp_t        sb [$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] alu_calc(input logic [2:0] f3, input logic [6:0] f7,
                                           input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0:    return f7[5] ? a - b : a + b;
      3'd1:    return a << b[4:0];
      3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3:    return (a < b) ? 32'd1 : 32'd0;
      3'd4:    return a ^ b;
      3'd5:    return f7[5] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [31:0] rdata = '0;
    logic [31:0] rdval = '0;
    logic [31:0] pend  = '0;
    int          cnt   = 0;

    alu_rr_sequencer #(.XLEN(32), .REG_ADDR_W(5), .ALU_LATENCY(LAT)) u_dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .issue_valid     (issue_valid[g]),
      .issue_ready     (issue_ready[g]),
      .issue_rs1       (issue_rs1),
      .issue_rs2       (issue_rs2),
      .issue_rd        (issue_rd),
      .issue_funct3    (issue_funct3),
      .issue_funct7    (issue_funct7),
      .rf_read_addr    (raddr[g]),
      .rf_read_data    (rdata),
      .alu_enable      (alu_en[g]),
      .alu_funct3      (a_f3[g]),
      .alu_funct7      (a_f7[g]),
      .alu_rs1_value   (op_a[g]),
      .alu_rs2_value   (op_b[g]),
      .alu_rd_value    (rdval),
      .rf_write_enable (we[g]),
      .rf_write_addr   (waddr[g]),
      .rf_write_data   (wdata[g]),
      .done            (done[g]),
      .illegal         (ill[g])
    );

    // Result shows garbage until LAT edges after the enable edge.
    always @(posedge clock) begin
      rdata <= rf_mem[raddr[g]];
      if (alu_en[g]) begin
        pend <= alu_calc(a_f3[g], a_f7[g], op_a[g], op_b[g]);
        if (LAT == 1) rdval <= alu_calc(a_f3[g], a_f7[g], op_a[g], op_b[g]);
        else begin
          rdval <= 32'hDEAD_BEEF;
          cnt   <= LAT - 1;
        end
      end else if (cnt > 0) begin
        cnt <= cnt - 1;
        if (cnt == 1) rdval <= pend;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    logic hit;
    if (reset_n) begin
      for (int i = 0; i < 2; i++) begin
        hit = (sb.size() > 0) && (sb[0].inst == i);
        if (hit) e = sb[0];
        if (alu_en[i] || we[i] || ill[i])
          check_eq("exclusive", int'(alu_en[i]) + int'(we[i]) + int'(ill[i]), 1);
        if (hit && e.legal && cyc == e.acc)     check_eq("read_rs1", raddr[i], e.rs1);
        if (hit && e.legal && cyc == e.acc + 1) check_eq("read_rs2", raddr[i], e.rs2);
        if (hit && (!e.legal || cyc >= e.acc + 2)) check_eq("read_idle", raddr[i], 0);
        if (alu_en[i]) begin
          if (!hit || !e.legal) check_eq("stray_alu_en", alu_en[i], 0);
          else begin
            check_eq("en_cycle", cyc, e.acc + 3);
            check_eq("op_a", op_a[i], e.a);
            check_eq("op_b", op_b[i], e.b);
            check_eq("en_f3", a_f3[i], e.f3);
            check_eq("en_f7", a_f7[i], e.f7);
          end
        end
        if (done[i]) begin
          if (!hit) check_eq("stray_done", done[i], 0);
          else begin
            check_eq("done_cycle", cyc, e.legal ? e.acc + 3 + e.lat : e.acc);
            check_eq("illegal", ill[i], !e.legal);
            check_eq("write_en", we[i], e.legal && (e.rd != 0));
            check_eq("ready_at_done", issue_ready[i], 0);
            check_eq("done_f3", a_f3[i], e.f3);
            if (e.legal) check_eq("write_data", wdata[i], e.res);
            if (we[i]) check_eq("write_addr", waddr[i], e.rd);
            void'(sb.pop_front());
          end
        end else if (ill[i]) check_eq("stray_illegal", ill[i], 0);
        if (we[i] && !done[i]) check_eq("stray_we", we[i], 0);
      end
    end
  end

  // Call right after a rising edge; returns right after the accepting edge.
  task automatic issue(input int inst, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic [2:0] f3, input logic [6:0] f7,
                       input logic legal, input logic [31:0] res, input logic hold,
                       output int acc);
    exp_t e;
    issue_rs1 = rs1; issue_rs2 = rs2; issue_rd = rd;
    issue_funct3 = f3; issue_funct7 = f7;
    issue_valid[inst] = 1'b1;
    acc = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clock);
      if (issue_ready[inst]) begin
        @(posedge clock);
        #1;
        acc = cyc;
        break;
      end
    end
    if (!hold) issue_valid[inst] = 1'b0;
    if (acc < 0) check_eq("accept_timeout", issue_ready[inst], 1);
    else begin
      e.inst = inst; e.acc = acc; e.lat = (inst == 0) ? 1 : 3; e.legal = legal;
      e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.f3 = f3; e.f7 = f7;
      e.a = rf_mem[rs1]; e.b = rf_mem[rs2]; e.res = res;
      sb.push_back(e);
    end
  endtask

  task automatic drain(input int inst);
    int n;
    n = 0;
    while (sb.size() > 0 && n < 60) begin
      @(negedge clock);
      #1;
      n++;
    end
    check_eq("drain", sb.size(), 0);
    sb.delete();
    @(negedge clock);
    #1;
    check_eq("ready_after", issue_ready[inst], 1);
  endtask

  task automatic check_idle(input int i);
    check_eq("rst_ready", issue_ready[i], 1);
    check_eq("rst_ctrl", {raddr[i], alu_en[i], a_f3[i], a_f7[i], we[i], waddr[i], done[i], ill[i]}, 0);
    check_eq("rst_operands", {op_a[i], op_b[i]}, 0);
    check_eq("rst_wdata", wdata[i], 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_a, acc_b;
    reset_n = 1'b0;
    issue_valid[0] = 1'b0; issue_valid[1] = 1'b0;
    issue_rs1 = '0; issue_rs2 = '0; issue_rd = '0; issue_funct3 = '0; issue_funct7 = '0;
    for (int r = 0; r < 32; r++) rf_mem[r] = 32'h100 + r;
    rf_mem[1] = 32'd5; rf_mem[2] = 32'd7;
    rf_mem[4] = 32'h8000_0000; rf_mem[5] = 32'd4;
    repeat (3) @(posedge clock);
    #1;
    check_idle(0);
    check_idle(1);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // ADD x3 = x1 + x2
    issue(0, 5'd1, 5'd2, 5'd3, 3'd0, 7'h00, 1'b1, 32'd12, 1'b0, acc_a);
    drain(0);

    // SUB into x0: full sequence, no write
    rf_mem[1] = 32'd9; rf_mem[2] = 32'd4;
    @(posedge clock); #1;
    issue(0, 5'd1, 5'd2, 5'd0, 3'd0, 7'h20, 1'b1, 32'd5, 1'b0, acc_a);
    drain(0);

    // Illegal encodings
    @(posedge clock); #1;
    issue(0, 5'd1, 5'd2, 5'd3, 3'd1, 7'h20, 1'b0, 32'd0, 1'b0, acc_a);
    drain(0);
    @(posedge clock); #1;
    issue(1, 5'd1, 5'd2, 5'd3, 3'd0, 7'h01, 1'b0, 32'd0, 1'b0, acc_a);
    drain(1);

    // SRA with latency 3
    @(posedge clock); #1;
    issue(1, 5'd4, 5'd5, 5'd6, 3'd5, 7'h20, 1'b1, 32'hF800_0000, 1'b0, acc_a);
    drain(1);

    // rs1 == rs2
    @(posedge clock); #1;
    issue(1, 5'd5, 5'd5, 5'd10, 3'd0, 7'h00, 1'b1, 32'd8, 1'b0, acc_a);
    drain(1);

    // Back-to-back with valid held; fields change while busy
    @(posedge clock); #1;
    issue(0, 5'd1, 5'd2, 5'd8, 3'd6, 7'h00, 1'b1, 32'd13, 1'b1, acc_a);
    issue(0, 5'd2, 5'd1, 5'd9, 3'd3, 7'h00, 1'b1, 32'd1, 1'b0, acc_b);
    check_eq("b2b_interval", acc_b - acc_a, 6);
    drain(0);

    // Reset during WAIT drops the operation
    @(posedge clock); #1;
    issue(1, 5'd1, 5'd2, 5'd11, 3'd0, 7'h00, 1'b1, 32'd13, 1'b0, acc_a);
    repeat (5) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check_idle(1);
    sb.delete();
    @(negedge clock);
    reset_n = 1'b1;
    repeat (10) @(negedge clock);

    // Recovery after reset
    @(posedge clock); #1;
    issue(1, 5'd4, 5'd5, 5'd12, 3'd5, 7'h00, 1'b1, 32'h0800_0000, 1'b0, acc_a);
    drain(1);

    repeat (3) @(posedge clock);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
